// File: rtl/seg_fun_pkg.sv
// Shared definitions for the seven-segment scroll multiplexer:
// the display mode encoding and the hex-to-segment lookup table.
package seg_fun_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    // Active-high segments, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to seven-segment pattern decoder.
module seg_hex_decoder
    import seg_fun_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Straight table lookup; the table lives in the package so other blocks can share it.
    always_comb begin
        seg = HEX_SEG[hex];
    end

endmodule

// File: rtl/seg_scroll_mux.sv
// Multiplexed seven-segment driver with a small nibble message buffer that can be
// shown statically, scrolled left/right, or blinked. A scan counter walks the
// digit enables; a separate step counter paces scrolling and blinking.
module seg_scroll_mux
    import seg_fun_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_LEN    = 16,
    parameter int SCAN_DIV   = 1000,
    parameter int STEP_DIV   = 2_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [3:0]                 wr_data,
    input  logic [1:0]                 mode,
    input  logic                       run,
    output logic [6:0]                 seg,
    output logic [NUM_DIGITS-1:0]      dig_sel,
    output logic                       step_tick
);

    localparam int ADDR_W = $clog2(MSG_LEN);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int STEP_W = $clog2(STEP_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SCAN_W-1:0] scan_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic [IDX_W-1:0]  digit_idx;
    logic [ADDR_W-1:0] offset;
    logic              blink_vis;   // 1 = digits visible, 0 = blanked
    logic [3:0]        msg_buf [MSG_LEN];

    logic              scan_tc;
    logic              step_evt;
    logic [ADDR_W-1:0] disp_addr;
    logic [3:0]        disp_nibble;
    logic [6:0]        dec_seg;

    // Terminal-count detection and the buffer entry feeding the current digit.
    // MSG_LEN is a power of two, so the address add wraps naturally.
    always_comb begin
        scan_tc     = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
        step_evt    = run && (step_cnt == STEP_W'(STEP_DIV - 1));
        disp_addr   = offset + ADDR_W'(digit_idx);
        disp_nibble = msg_buf[disp_addr];
    end

    // Scan counter and digit index: free-running, independent of run.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_tc) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // Step counter, offset and blink phase; mode is only looked at on a step event.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt  <= '0;
            step_tick <= 1'b0;
            offset    <= '0;
            blink_vis <= 1'b1;
        end else begin
            step_tick <= step_evt;
            if (step_evt) begin
                step_cnt <= '0;
                case (mode_e'(mode))
                    MODE_LEFT:  offset <= offset + ADDR_W'(1);
                    MODE_RIGHT: offset <= offset - ADDR_W'(1);
                    default:    offset <= offset;
                endcase
                blink_vis <= (mode_e'(mode) == MODE_BLINK) ? ~blink_vis : 1'b1;
            end else if (run) begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
        end
    end

    // Message buffer: cleared by reset, otherwise written one nibble per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_buf[i] <= 4'h0;
            end
        end else if (wr_en) begin
            msg_buf[wr_addr] <= wr_data;
        end
    end

    seg_hex_decoder u_dec (
        .hex (disp_nibble),
        .seg (dec_seg)
    );

    // Registered digit/segment drive; everything dark while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg     <= 7'h00;
            dig_sel <= '0;
        end else begin
            seg     <= blink_vis ? dec_seg : 7'h00;
            dig_sel <= NUM_DIGITS'(1) << digit_idx;
        end
    end

endmodule

// File: tb/tb_seg_scroll_mux.sv
// Bench for seg_scroll_mux: directed phases followed by random traffic, checked
// cycle by cycle against a behavioural model through an expected-output queue.
module tb_seg_scroll_mux;

    localparam int NUM_DIGITS = 4;
    localparam int MSG_LEN    = 8;
    localparam int SCAN_DIV   = 2;
    localparam int STEP_DIV   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [1:0] mode = 2'b00;
    logic       run = 1'b1;
    logic [6:0] seg;
    logic [3:0] dig_sel;
    logic       step_tick;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit stop = 1'b0;

    logic [11:0] exp_q[$];

    logic [6:0] hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_scroll_mux #(
        .NUM_DIGITS (NUM_DIGITS),
        .MSG_LEN    (MSG_LEN),
        .SCAN_DIV   (SCAN_DIV),
        .STEP_DIV   (STEP_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mode      (mode),
        .run       (run),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .step_tick (step_tick)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: scan position, step position, offset, phase and buffer as plain integers.
    int m_scan, m_idx, m_step, m_off;
    bit m_vis;
    int m_buf [MSG_LEN];

    always @(posedge clk) begin
        logic [6:0] e_seg;
        logic [3:0] e_dig;
        logic       e_tick;
        if (!stop) begin
            if (rst) begin
                exp_q.push_back(12'h000);
                m_scan = 0; m_idx = 0; m_step = 0; m_off = 0; m_vis = 1'b1;
                for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 0;
            end else begin
                e_seg  = m_vis ? hex_tab[m_buf[(m_off + m_idx) % MSG_LEN]] : 7'h00;
                e_dig  = 4'(1 << m_idx);
                e_tick = run && (m_step == STEP_DIV - 1);
                exp_q.push_back({e_tick, e_dig, e_seg});
                if (m_scan == SCAN_DIV - 1) begin
                    m_scan = 0;
                    m_idx  = (m_idx + 1) % NUM_DIGITS;
                end else begin
                    m_scan++;
                end
                if (e_tick) begin
                    m_step = 0;
                    if (mode == 2'b01) m_off = (m_off + 1) % MSG_LEN;
                    if (mode == 2'b10) m_off = (m_off + MSG_LEN - 1) % MSG_LEN;
                    m_vis = (mode == 2'b11) ? !m_vis : 1'b1;
                end else if (run) begin
                    m_step++;
                end
                if (wr_en) m_buf[wr_addr] = int'(wr_data);
            end
        end
    end

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        logic [11:0] exp_v;
        logic [11:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {step_tick, dig_sel, seg};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL out cyc=%0d seg act=%h exp=%h dig_sel act=%b exp=%b tick act=%b exp=%b",
                         cyc, act_v[6:0], exp_v[6:0], act_v[10:7], exp_v[10:7], act_v[11], exp_v[11]);
            end
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic write_nib(input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = 4'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        // Reset, then an empty buffer scanning in static mode
        rst = 1'b1; run = 1'b1; mode = 2'b00;
        idle(3);
        rst = 1'b0;
        idle(40);

        // Load 1..8 and scroll left through a full wrap and beyond
        for (int i = 0; i < MSG_LEN; i++) write_nib(i, i + 1);
        mode = 2'b01;
        idle(80);

        // Scroll right
        mode = 2'b10;
        idle(40);

        // Blink
        mode = 2'b11;
        idle(60);

        // Scroll left, then pause with a write during the pause
        mode = 2'b01;
        idle(20);
        run = 1'b0;
        idle(10);
        write_nib(m_off % MSG_LEN, 4'hA);
        write_nib((m_off + 1) % MSG_LEN, 4'hF);
        idle(28);
        run = 1'b1;
        idle(20);

        // Reset pulse mid-scroll
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        idle(30);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 199) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, MSG_LEN - 1));
            wr_data = 4'($urandom_range(0, 15));
            run     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;

        // Drain and final report
        stop = 1'b1;
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending act=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scroll_mux.md
SEG_SCROLL_MUX -- requirements
Module: seg_scroll_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter MSG_LEN, default 16: message buffer depth in nibbles, power of two, at least NUM_DIGITS.
REQ-003 Parameter SCAN_DIV, default 1000: clocks per digit scan slot, at least 2.
REQ-004 Parameter STEP_DIV, default 2_000_000: clocks per scroll/blink step, at least 2.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 wr_en  in  1  write strobe for the message buffer.
REQ-009 wr_addr  in  clog2(MSG_LEN)  message buffer write address.
REQ-010 wr_data  in  4  hex nibble to store.
REQ-011 mode  in  2  00 static, 01 scroll left, 10 scroll right, 11 blink.
REQ-012 run  in  1  when high, the step counter advances; when low, the offset and blink phase freeze.
REQ-013 seg  out  7  segment drive, active-high, seg[0]=a .. seg[6]=g, registered.
REQ-014 dig_sel  out  NUM_DIGITS  one-hot active-high digit enable, registered.
REQ-015 step_tick  out  1  one-clock pulse on each step counter terminal count, registered.

Function
REQ-016 The scan counter shall count 0..SCAN_DIV-1 continuously; at terminal count, the digit index shall advance, wrapping from NUM_DIGITS-1 to 0.
REQ-017 The step counter shall count 0..STEP_DIV-1 only while run=1; the terminal count shall assert step_tick on the next cycle and wrap the step counter to 0.
REQ-018 On a step tick, mode 01 shall increment the offset modulo MSG_LEN (MSG_LEN-1 wraps to 0), and mode 10 shall decrement it (0 wraps to MSG_LEN-1).
REQ-019 On a step tick, modes 00 and 11 shall hold the offset.
REQ-020 On a step tick, mode 11 shall toggle the blink phase; in all other modes, the blink phase shall be forced to visible.
REQ-021 Digit index i shall display the buffer entry at (offset+i) mod MSG_LEN, decoded hex 0-F to segments ('0'=7'h3F, '1'=7'h06, 'A'=7'h77, 'F'=7'h71).
REQ-022 seg and dig_sel shall be registered, showing the current index, offset and buffer contents one cycle after any change to them.
REQ-023 In blink mode with the phase blanked, seg shall be 7'h00 while dig_sel continues to scan.
REQ-024 A write shall take effect at the clock edge; the new nibble shall be visible on seg from the following cycle if that entry is displayed.
REQ-025 A mode change shall be sampled only on step ticks; the offset shall be preserved across mode changes.
REQ-026 When run=0, the step counter, offset and blink phase shall freeze, while scanning and writes continue.
REQ-027 If a step tick coincides with a write, both shall take effect on the same edge.

Reset
REQ-028 rst=1 at a clock edge shall clear the scan counter, step counter, digit index, offset and blink phase (visible), and all buffer entries to 0.
REQ-029 While in reset, seg=7'h00, dig_sel=0 and step_tick=0.
REQ-030 On the first cycle after rst deasserts, dig_sel shall be 1 and seg shall be 7'h3F.
REQ-031 Reset asserted mid-scroll shall abort immediately, with no partial step or write completing on that edge.

Structure
REQ-032 Shared package seg_fun_pkg shall hold the mode enum (MODE_STATIC, MODE_LEFT, MODE_RIGHT, MODE_BLINK) and the 16-entry hex-to-segment constant table.
REQ-033 Hex decoding shall be a combinational sub-module seg_hex_decoder (4 in, 7 out), instantiated once after the digit-select mux.
REQ-034 Counter widths shall be derived from parameters via clog2; no hard-coded widths.

Verification (NUM_DIGITS=4, MSG_LEN=8, SCAN_DIV=2, STEP_DIV=8)
REQ-035 Reset release with an empty buffer -> dig_sel cycles 0001,0010,0100,1000,0001 every 2 clocks; seg=7'h3F throughout; step_tick pulses every 8 clocks while run=1.
REQ-036 Write 1,2,3,4,5,6,7,8 to addresses 0..7, mode=01, run=1 -> the offset steps 0..7 then wraps to 0; at offset 6, the digits show 7,8,1,2.
REQ-037 Same buffer, mode=10 from offset 0 -> the first step gives offset 7; digit 0 shows 8 and digit 1 shows 1.
REQ-038 mode=11, run=1 -> seg alternates between the decoded value and 7'h00 on each step_tick; dig_sel never stops scanning.
REQ-039 run=0 mid-scroll for 40 clocks -> no step_tick and the offset is unchanged; a write to a displayed address during the pause appears on seg the next cycle.
REQ-040 rst pulsed one cycle during scrolling at offset 5 -> the next cycle has seg=7'h00 and dig_sel=0; after release, the offset is 0 and all digits show '0'.
